// File: rtl/if_prefetch_queue_if.sv
// Bundles the ROM fetch handshake, the fetch-stage handshake and the flush request.
// master: the prefetch queue. slave: the ROM/core environment that drives it.
interface if_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              flush_i;
    logic [ADDR_W-1:0] flush_addr_i;
    logic              rom_req_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_gnt_i;
    logic              rom_rvalid_i;
    logic [DATA_W-1:0] rom_rdata_i;
    logic              ins_valid_o;
    logic [DATA_W-1:0] ins_o;
    logic [ADDR_W-1:0] ins_addr_o;
    logic              ins_ready_i;

    modport master (
        input  flush_i, flush_addr_i, rom_gnt_i, rom_rvalid_i, rom_rdata_i, ins_ready_i,
        output rom_req_o, rom_addr_o, ins_valid_o, ins_o, ins_addr_o
    );

    modport slave (
        output flush_i, flush_addr_i, rom_gnt_i, rom_rvalid_i, rom_rdata_i, ins_ready_i,
        input  rom_req_o, rom_addr_o, ins_valid_o, ins_o, ins_addr_o
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Purpose: instruction prefetch queue between ROM and fetch stage; optional IF_PREFETCH_BYPASS_EN bypass.
// Latency: rom_rvalid_i to ins_valid_o is 1 cycle (0 cycles through the bypass when the queue is empty).
// Backpressure: requests stop once queued plus kept in-flight words would exceed DEPTH; flush drops in-flight data.
module if_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rest,
    if_prefetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_pending;
    logic [CW-1:0]     r_discard;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_ret_pc;
    logic [DATA_W-1:0] r_mem_dat [DEPTH];
    logic [ADDR_W-1:0] r_mem_adr [DEPTH];

    logic              w_req;
    logic              w_gnt;
    logic              w_keep;
    logic              w_drop;
    logic              w_rsp_owned;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic [CW-1:0]     w_discard_flush;

    // Sums are widened by one bit so the comparison against DEPTH can never wrap.
    assign w_req = rest && !bus.flush_i
                && (({1'b0, r_count}   + {1'b0, r_pending}) < DEPTH_L)
                && (({1'b0, r_pending} + {1'b0, r_discard}) < DEPTH_L);

    assign w_gnt        = w_req && bus.rom_gnt_i;
    assign w_drop       = bus.rom_rvalid_i && (r_discard != '0);
    assign w_keep       = bus.rom_rvalid_i && (r_discard == '0) && (r_pending != '0);
    assign w_rsp_owned  = bus.rom_rvalid_i && ((r_discard != '0) || (r_pending != '0));
    assign w_empty      = (r_count == '0);
    assign w_pop        = !w_empty && bus.ins_ready_i;
    assign w_discard_flush = r_discard + r_pending - CW'(w_rsp_owned);

    assign bus.rom_req_o  = w_req;
    assign bus.rom_addr_o = r_fetch_pc;

`ifdef IF_PREFETCH_BYPASS_EN
    logic w_byp;

    // An empty queue lets a kept response go straight to the fetch stage.
    assign w_byp           = w_keep && w_empty && !bus.flush_i;
    assign w_push          = w_keep && !(w_byp && bus.ins_ready_i);
    assign bus.ins_valid_o = !w_empty || w_byp;
    assign bus.ins_o       = w_byp ? bus.rom_rdata_i : r_mem_dat[r_rd_ptr];
    assign bus.ins_addr_o  = w_byp ? r_ret_pc        : r_mem_adr[r_rd_ptr];
`else
    assign w_push          = w_keep;
    assign bus.ins_valid_o = !w_empty;
    assign bus.ins_o       = r_mem_dat[r_rd_ptr];
    assign bus.ins_addr_o  = r_mem_adr[r_rd_ptr];
`endif

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_count    <= '0;
            r_pending  <= '0;
            r_discard  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= RESET_PC;
            r_ret_pc   <= RESET_PC;
        end else if (bus.flush_i) begin
            // Everything still owed by the ROM becomes discard, minus a response landing right now.
            r_count    <= '0;
            r_pending  <= '0;
            r_discard  <= w_discard_flush;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= bus.flush_addr_i;
            r_ret_pc   <= bus.flush_addr_i;
        end else begin
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_pending <= r_pending + CW'(w_gnt) - CW'(w_keep);
            r_discard <= r_discard - CW'(w_drop);
            if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (w_keep) begin
                r_ret_pc <= r_ret_pc + ADDR_W'(4);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_dat[i] <= '0;
                r_mem_adr[i] <= '0;
            end
        end else if (w_push && !bus.flush_i) begin
            r_mem_dat[r_wr_ptr] <= bus.rom_rdata_i;
            r_mem_adr[r_wr_ptr] <= r_ret_pc;
        end
    end
endmodule
